regfile_writeback: RTL and testbench

Writeback stage sitting directly upstream of the RV64I register file: it merges ALU results and load-unit results onto the register file's single write port (write enable, rd address, 64-bit rd data). Load data is byte-lane aligned and sign/zero extended here. A 2-entry load queue absorbs write-port conflicts. Ordering checks prevent a younger ALU write from being overwritten by an older queued load.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/regfile_writeback_if.sv | 57 +++++
 rtl/wb_load_queue.sv | 83 ++++++++
 rtl/regfile_writeback.sv | 144 ++++++++++++++
 tb/tb_regfile_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64I constants for the writeback slice: register/data widths,
// load funct3 encodings, writeback source select and load extension helper.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] LOAD_LB     = 3'b000;
    localparam logic [2:0] LOAD_LH     = 3'b001;
    localparam logic [2:0] LOAD_LW     = 3'b010;
    localparam logic [2:0] LOAD_LD     = 3'b011;
    localparam logic [2:0] LOAD_LBU    = 3'b100;
    localparam logic [2:0] LOAD_LHU    = 3'b101;
    localparam logic [2:0] LOAD_LWU    = 3'b110;
    localparam logic [2:0] LOAD_LD_ALT = 3'b111;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LQ   = 2'd2
    } wb_src_e;

    // Shift the addressed bytes down to bit 0, then truncate and extend.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      funct3,
        input logic [2:0]      byte_off
    );
        logic [XLEN-1:0] sh;
        sh = raw >> {byte_off, 3'b000};
        case (funct3)
            LOAD_LB:  return {{(XLEN-8){sh[7]}},   sh[7:0]};
            LOAD_LH:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
            LOAD_LW:  return {{(XLEN-32){sh[31]}}, sh[31:0]};
            LOAD_LBU: return {{(XLEN-8){1'b0}},    sh[7:0]};
            LOAD_LHU: return {{(XLEN-16){1'b0}},   sh[15:0]};
            LOAD_LWU: return {{(XLEN-32){1'b0}},   sh[31:0]};
            default:  return sh;    // LOAD_LD and LOAD_LD_ALT
        endcase
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bus bundle for regfile_writeback: ALU result port, load response port,
// register-file write port and load-queue occupancy.
// Optional decode bypass ports exist when REGFILE_WB_BYPASS_EN is defined.
interface regfile_writeback_if #(
    parameter int unsigned LQ_DEPTH = 2
);
    import riscv_pkg::*;

    localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd_addr;
    logic [XLEN-1:0]   alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd_addr;
    logic [2:0]        ld_funct3;
    logic [2:0]        ld_byte_off;
    logic [XLEN-1:0]   ld_raw;

    logic              write_en;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic [CNT_W-1:0]  lq_count;

`ifdef REGFILE_WB_BYPASS_EN
    logic [REG_AW-1:0] byp_rs1_addr;
    logic [REG_AW-1:0] byp_rs2_addr;
    logic              byp_rs1_hit;
    logic              byp_rs2_hit;
    logic [XLEN-1:0]   byp_rs1_data;
    logic [XLEN-1:0]   byp_rs2_data;
`endif

    modport master (
`ifdef REGFILE_WB_BYPASS_EN
        output byp_rs1_addr, byp_rs2_addr,
        input  byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data,
`endif
        output alu_valid, alu_rd_addr, alu_data,
        output ld_valid, ld_rd_addr, ld_funct3, ld_byte_off, ld_raw,
        input  alu_ready, ld_ready, write_en, rd_addr, rd_data, lq_count
    );

    modport slave (
`ifdef REGFILE_WB_BYPASS_EN
        input  byp_rs1_addr, byp_rs2_addr,
        output byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data,
`endif
        input  alu_valid, alu_rd_addr, alu_data,
        input  ld_valid, ld_rd_addr, ld_funct3, ld_byte_off, ld_raw,
        output alu_ready, ld_ready, write_en, rd_addr, rd_data, lq_count
    );

endinterface

// File: rtl/wb_load_queue.sv
// Load queue for regfile_writeback: FIFO of {rd, extended data}.
// Exposes full/empty/count, the head entry and every entry's rd with a
// valid mask so the writeback arbiter can run its WAW compare.
// DEPTH must be a power of two so pointers wrap naturally.
module wb_load_queue #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned DW    = 64,
    parameter  int unsigned AW    = 5,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [AW-1:0]    i_push_rd,
    input  logic [DW-1:0]    i_push_data,
    input  logic             i_pop,
    output logic [AW-1:0]    o_head_rd,
    output logic [DW-1:0]    o_head_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic [AW-1:0]    o_entry_rd [DEPTH],
    output logic [DEPTH-1:0] o_entry_valid
);

    logic [AW-1:0]    r_rd   [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rel;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head_rd   = r_rd[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_entry_rd  = r_rd;

    // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_rd[r_wr_ptr]   <= i_push_rd;
                r_data[r_wr_ptr] <= i_push_data;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry i is live when its distance from the head is below the count.
    always_comb begin
        o_entry_valid = '0;
        w_rel         = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_rel            = PTR_W'(i) - r_rd_ptr;
            o_entry_valid[i] = (CNT_W'(w_rel) < r_count);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// RV64I writeback stage: merges ALU results and extended load data onto the
// single register-file write port. Loads always pass through wb_load_queue;
// the arbiter drains the queue when full or on a WAW hazard against the ALU.
// Optional macro REGFILE_WB_BYPASS_EN adds combinational decode bypass ports.
module regfile_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_writeback_if.slave wb
);

    localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

    logic                w_lq_full;
    logic                w_lq_empty;
    logic [CNT_W-1:0]    w_lq_count;
    logic [REG_AW-1:0]   w_head_rd;
    logic [XLEN-1:0]     w_head_data;
    logic [REG_AW-1:0]   w_entry_rd [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] w_entry_valid;
    logic                w_lq_push;
    logic                w_lq_pop;
    logic [XLEN-1:0]     w_ld_data;
    logic                w_ld_ready;
    logic                w_alu_ready;
    logic                w_waw;
    wb_src_e             w_src;
    logic [REG_AW-1:0]   w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;
    logic                w_commit;

    logic                r_write_en;
    logic [REG_AW-1:0]   r_rd_addr;
    logic [XLEN-1:0]     r_rd_data;

    // Full is the pre-dequeue state, so a full queue never accepts this cycle.
    assign w_ld_ready = !rst && !w_lq_full;
    assign w_lq_push  = wb.ld_valid && w_ld_ready;
    assign w_ld_data  = load_extend(wb.ld_raw, wb.ld_funct3, wb.ld_byte_off);

    wb_load_queue #(
        .DEPTH (LQ_DEPTH),
        .DW    (XLEN),
        .AW    (REG_AW)
    ) u_lq (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_lq_push),
        .i_push_rd     (wb.ld_rd_addr),
        .i_push_data   (w_ld_data),
        .i_pop         (w_lq_pop),
        .o_head_rd     (w_head_rd),
        .o_head_data   (w_head_data),
        .o_full        (w_lq_full),
        .o_empty       (w_lq_empty),
        .o_count       (w_lq_count),
        .o_entry_rd    (w_entry_rd),
        .o_entry_valid (w_entry_valid)
    );

    // WAW: a valid ALU result targeting any queued load's rd must wait.
    always_comb begin
        w_waw = 1'b0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (w_entry_valid[i] && (w_entry_rd[i] == wb.alu_rd_addr)) begin
                w_waw = 1'b1;
            end
        end
        w_waw = w_waw && wb.alu_valid;
    end

    // Priority: full queue, WAW drain, ALU, queue drain, idle.
    always_comb begin
        w_src       = SRC_NONE;
        w_alu_ready = 1'b0;
        if (!rst) begin
            if (w_lq_full) begin
                w_src = SRC_LQ;
            end else if (w_waw) begin
                w_src = SRC_LQ;
            end else if (wb.alu_valid) begin
                w_src       = SRC_ALU;
                w_alu_ready = 1'b1;
            end else if (!w_lq_empty) begin
                w_src = SRC_LQ;
            end
        end
    end

    assign w_lq_pop = (w_src == SRC_LQ);

    // Selected source's destination and data.
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        case (w_src)
            SRC_ALU: begin
                w_sel_rd   = wb.alu_rd_addr;
                w_sel_data = wb.alu_data;
            end
            SRC_LQ: begin
                w_sel_rd   = w_head_rd;
                w_sel_data = w_head_data;
            end
            default: ;
        endcase
    end

    // x0 targets are consumed but never written.
    assign w_commit = (w_src != SRC_NONE) && (w_sel_rd != '0);

    // Register-file write port register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_en <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
        end else begin
            r_write_en <= w_commit;
            if (w_commit) begin
                r_rd_addr <= w_sel_rd;
                r_rd_data <= w_sel_data;
            end
        end
    end

    assign wb.alu_ready = w_alu_ready;
    assign wb.ld_ready  = w_ld_ready;
    assign wb.write_en  = r_write_en;
    assign wb.rd_addr   = r_rd_addr;
    assign wb.rd_data   = r_rd_data;
    assign wb.lq_count  = w_lq_count;

`ifdef REGFILE_WB_BYPASS_EN
    assign wb.byp_rs1_hit  = r_write_en && (r_rd_addr != '0) && (r_rd_addr == wb.byp_rs1_addr);
    assign wb.byp_rs2_hit  = r_write_en && (r_rd_addr != '0) && (r_rd_addr == wb.byp_rs2_addr);
    assign wb.byp_rs1_data = r_rd_data;
    assign wb.byp_rs2_data = r_rd_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed + short random bench for regfile_writeback with a write scoreboard.
module tb_regfile_writeback;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_writeback_if #(.LQ_DEPTH(2)) wb ();

    regfile_writeback #(.LQ_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

`ifdef REGFILE_WB_BYPASS_EN
    initial begin
        wb.byp_rs1_addr = '0;
        wb.byp_rs2_addr = '0;
    end
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         ld_q[$];
    logic        alu_pend = 1'b0;
    wr_t         alu_exp;
    logic [63:0] last_x7 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent load model: byte gather, then explicit extension.
    function automatic logic [63:0] exp_load(input logic [63:0] raw, input logic [2:0] f3,
                                             input logic [2:0] off);
        int unsigned nb;
        logic [63:0] v;
        logic        sgn;
        v = '0;
        case (f3[1:0])
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 8;
        endcase
        sgn = !f3[2];
        for (int b = 0; b < int'(nb); b++) begin
            if (int'(off) + b <= 7) v[8*b +: 8] = raw[8*(int'(off)+b) +: 8];
        end
        if (sgn && nb < 8) begin
            for (int k = 8*int'(nb); k < 64; k++) v[k] = v[8*nb-1];
        end
        return v;
    endfunction

    // Scoreboard: check the write reflected by the last edge, then log accepts
    // that the next edge will commit.
    always @(negedge clk) begin
        if (rst) begin
            ld_q.delete();
            alu_pend = 1'b0;
        end else begin
            if (alu_pend) begin
                chk("alu_write_en", wb.write_en, 1'b1);
                chk("alu_write_rd", wb.rd_addr, alu_exp.rd);
                chk("alu_write_data", wb.rd_data, alu_exp.data);
                alu_pend = 1'b0;
            end else if (wb.write_en) begin
                if (ld_q.size() == 0) begin
                    chk("unexpected_write", wb.write_en, 1'b0);
                end else begin
                    wr_t e;
                    e = ld_q.pop_front();
                    chk("ld_write_rd", wb.rd_addr, e.rd);
                    chk("ld_write_data", wb.rd_data, e.data);
                end
            end
            if (wb.write_en && wb.rd_addr == 5'd7) last_x7 = wb.rd_data;
            if (wb.alu_valid && wb.alu_ready && wb.alu_rd_addr != 5'd0) begin
                alu_pend     = 1'b1;
                alu_exp.rd   = wb.alu_rd_addr;
                alu_exp.data = wb.alu_data;
            end
            if (wb.ld_valid && wb.ld_ready && wb.ld_rd_addr != 5'd0) begin
                wr_t n;
                n.rd   = wb.ld_rd_addr;
                n.data = exp_load(wb.ld_raw, wb.ld_funct3, wb.ld_byte_off);
                ld_q.push_back(n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
        wb.alu_valid   = v;
        wb.alu_rd_addr = rd;
        wb.alu_data    = d;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [2:0] off, input logic [63:0] raw);
        wb.ld_valid    = v;
        wb.ld_rd_addr  = rd;
        wb.ld_funct3   = f3;
        wb.ld_byte_off = off;
        wb.ld_raw      = raw;
    endtask

    task automatic idle();
        drive_alu(1'b0, 5'd0, 64'd0);
        drive_ld(1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
    endtask

    // Lone load: no write one cycle after accept, write with exp two cycles after.
    task automatic load_direct(input string tag, input logic [2:0] f3, input logic [2:0] off,
                               input logic [63:0] raw, input logic [63:0] exp);
        drive_ld(1'b1, 5'd12, f3, off, raw);
        @(negedge clk);
        chk({tag, "_ld_ready"}, wb.ld_ready, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk({tag, "_n1_write_en"}, wb.write_en, 1'b0);
        chk({tag, "_n1_lq_count"}, wb.lq_count, 2'd1);
        step();
        @(negedge clk);
        chk({tag, "_n2_write_en"}, wb.write_en, 1'b1);
        chk({tag, "_n2_rd"}, wb.rd_addr, 5'd12);
        chk({tag, "_n2_data"}, wb.rd_data, exp);
        step();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 20 && (wb.lq_count != 0 || ld_q.size() != 0 || alu_pend); c++) step();
        step();
        chk({tag, "_lq_count"}, wb.lq_count, 2'd0);
        chk({tag, "_scoreboard_left"}, ld_q.size(), 0);
        chk({tag, "_alu_pending"}, alu_pend, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a_acc, l_acc, saw_full;
        logic [63:0] alu_d, ld_d;
        logic [2:0]  f3, off;

        // Reset with valids asserted: nothing accepted, outputs cleared.
        drive_alu(1'b1, 5'd1, 64'h1);
        drive_ld(1'b1, 5'd2, 3'd3, 3'd0, 64'h2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_write_en", wb.write_en, 1'b0);
        chk("rst_rd_addr", wb.rd_addr, 5'd0);
        chk("rst_rd_data", wb.rd_data, 64'd0);
        chk("rst_lq_count", wb.lq_count, 2'd0);
        chk("rst_ld_ready", wb.ld_ready, 1'b0);
        chk("rst_alu_ready", wb.alu_ready, 1'b0);
        step();
        idle();
        rst = 1'b0;
        step();

        // ALU only: accept in N, visible in N+1.
        drive_alu(1'b1, 5'd5, 64'h1234);
        @(negedge clk);
        chk("alu_ready_rd5", wb.alu_ready, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("alu_rd5_write_en", wb.write_en, 1'b1);
        chk("alu_rd5_rd_addr", wb.rd_addr, 5'd5);
        chk("alu_rd5_rd_data", wb.rd_data, 64'h1234);
        step();

        // Extension and alignment.
        load_direct("lb_off7", 3'b000, 3'd7, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        load_direct("lbu_off7", 3'b100, 3'd7, 64'h80FF_0000_0000_0000, 64'h0000_0000_0000_0080);
        load_direct("lw_off4", 3'b010, 3'd4, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_80FF_0000);
        load_direct("lh_off6", 3'b001, 3'd6, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_80FF);
        load_direct("lhu_off6", 3'b101, 3'd6, 64'h80FF_0000_0000_0000, 64'h0000_0000_0000_80FF);
        load_direct("lwu_off4", 3'b110, 3'd4, 64'h80FF_0000_0000_0000, 64'h0000_0000_80FF_0000);
        load_direct("ld_off0", 3'b011, 3'd0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
        load_direct("f3_111", 3'b111, 3'd0, 64'hF00D_0000_0000_0081, 64'hF00D_0000_0000_0081);

        // Contention: ALU rd3 and load rd4 every cycle.
        saw_full = 1'b0;
        alu_d    = 64'hA000;
        ld_d     = 64'hB000;
        for (int c = 0; c < 8; c++) begin
            drive_alu(1'b1, 5'd3, alu_d);
            drive_ld(1'b1, 5'd4, 3'b011, 3'd0, ld_d);
            @(negedge clk);
            if (wb.lq_count == 2'd2) begin
                saw_full = 1'b1;
                chk("full_alu_ready", wb.alu_ready, 1'b0);
                chk("full_ld_ready", wb.ld_ready, 1'b0);
            end
            a_acc = wb.alu_ready;
            l_acc = wb.ld_ready;
            step();
            if (a_acc) alu_d = alu_d + 64'd1;
            if (l_acc) ld_d = ld_d + 64'd1;
        end
        chk("contention_full_seen", saw_full, 1'b1);
        idle();
        drain("contention");

        // WAW: queued load to x7 blocks the ALU write to x7.
        drive_ld(1'b1, 5'd7, 3'b011, 3'd0, 64'h77);
        step();
        drive_ld(1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
        drive_alu(1'b1, 5'd7, 64'hA7A7);
        @(negedge clk);
        chk("waw_alu_blocked", wb.alu_ready, 1'b0);
        step();
        @(negedge clk);
        chk("waw_alu_released", wb.alu_ready, 1'b1);
        step();
        idle();
        step();
        step();
        chk("waw_final_x7", last_x7, 64'hA7A7);

        // x0: ALU and load consumed without a write.
        drive_alu(1'b1, 5'd0, 64'hDEAD);
        @(negedge clk);
        chk("x0_alu_ready", wb.alu_ready, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("x0_alu_no_write", wb.write_en, 1'b0);
        step();
        drive_ld(1'b1, 5'd0, 3'b011, 3'd0, 64'h1);
        @(negedge clk);
        chk("x0_ld_ready", wb.ld_ready, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("x0_ld_queued", wb.lq_count, 2'd1);
        step();
        @(negedge clk);
        chk("x0_ld_dequeued", wb.lq_count, 2'd0);
        chk("x0_ld_no_write", wb.write_en, 1'b0);
        step();

        // Reset mid-operation with two loads queued.
        drive_alu(1'b1, 5'd9, 64'h99);
        drive_ld(1'b1, 5'd10, 3'b011, 3'd0, 64'h10);
        step();
        drive_alu(1'b1, 5'd9, 64'h9A);
        drive_ld(1'b1, 5'd11, 3'b011, 3'd0, 64'h11);
        step();
        drive_ld(1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
        @(negedge clk);
        chk("pre_rst_lq_count", wb.lq_count, 2'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_write_en", wb.write_en, 1'b0);
        chk("mid_rst_rd_addr", wb.rd_addr, 5'd0);
        chk("mid_rst_rd_data", wb.rd_data, 64'd0);
        chk("mid_rst_lq_count", wb.lq_count, 2'd0);
        chk("mid_rst_alu_ready", wb.alu_ready, 1'b0);
        chk("mid_rst_ld_ready", wb.ld_ready, 1'b0);
        idle();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_lq_count", wb.lq_count, 2'd0);
        chk("post_rst_ld_ready", wb.ld_ready, 1'b1);
        chk("post_rst_write_en", wb.write_en, 1'b0);
        step();

        // Random mix against the scoreboard.
        for (int c = 0; c < 80; c++) begin
            if (!wb.alu_valid && $urandom_range(0, 2) != 0)
                drive_alu(1'b1, 5'($urandom_range(0, 15)), {$urandom, $urandom});
            if (!wb.ld_valid && $urandom_range(0, 1) != 0) begin
                f3  = 3'($urandom_range(0, 7));
                off = 3'($urandom_range(0, 7));
                case (f3[1:0])
                    2'd0:    off = off;
                    2'd1:    off = off & 3'b110;
                    2'd2:    off = off & 3'b100;
                    default: off = 3'd0;
                endcase
                drive_ld(1'b1, 5'($urandom_range(0, 15)), f3, off, {$urandom, $urandom});
            end
            @(negedge clk);
            a_acc = wb.alu_valid && wb.alu_ready;
            l_acc = wb.ld_valid && wb.ld_ready;
            step();
            if (a_acc) wb.alu_valid = 1'b0;
            if (l_acc) wb.ld_valid = 1'b0;
        end
        idle();
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
